snake_direction_ctrl: RTL
=========================

Name: snake_direction_ctrl

Overview:
- Upstream stage of the Snake Game Arcade datapath. It turns the left/right proximity flags from the ultrasonic comparator into the 2-bit `direction` bus that drives head-position update and wall-collision detection.
- Confirms a turn only after repeated consistent sensor samples.
- Queues one relative turn and commits it only on the end-of-move pulse, so `direction` never changes while a move is in progress.

Parameters:
- CONFIRM_SAMPLES, 3: consecutive identical valid command samples required to accept a turn (range 1..15).
- DIR_INIT, 2'b00: direction loaded at reset and on load_default.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running. When low, the block idles and `direction` is held.
- load_default  in  1  single-cycle pulse: restore DIR_INIT and drop any pending turn (new game).
- sample  in  1  single-cycle pulse: new esq/dir measurement is valid (interface timer end).
- esq  in  1  left object close (level, read only when sample=1).
- dir  in  1  right object close (level, read only when sample=1).
- move_done  in  1  single-cycle pulse: current snake move finished.
- direction  out  2  00 +X, 01 +Y, 10 -X, 11 -Y.
- turn_pending  out  1  a confirmed turn awaits move_done.
- turn_applied  out  1  one-cycle pulse, asserted the cycle `direction` changes.
- db_state  out  3  FSM state encoding, for debug.

Behaviour:
- **Reset (async):** direction=DIR_INIT, turn_pending=0, turn_applied=0, state=IDLE (db_state=000), confirm counter=0, pending register=NONE.
- **Command decode (only when sample=1):**
  - esq=1, dir=0 -> LEFT.
  - esq=0, dir=1 -> RIGHT.
  - 00 or 11 -> NONE. Both flags high is treated as no command.
- **Turn arithmetic (2-bit wrap):**
  - RIGHT: direction+1 (11 -> 00).
  - LEFT: direction-1 (00 -> 11).
  - A reversal is therefore impossible.
- **FSM states:** IDLE=000, LISTEN=001, CONFIRM=010, PENDING=011, RELEASE=100.
  - IDLE: enable=1 -> LISTEN.
  - LISTEN: sample with LEFT/RIGHT -> store candidate, counter=1. If CONFIRM_SAMPLES=1 go straight to PENDING, else go to CONFIRM. NONE -> stay.
  - CONFIRM:
    - Sample equal to candidate -> counter+1. When counter reaches CONFIRM_SAMPLES -> PENDING.
    - Sample with the opposite command -> candidate replaced, counter=1.
    - Sample NONE -> LISTEN, counter=0.
    - Cycles without sample do not change the counter.
  - PENDING:
    - turn_pending=1.
    - All samples are ignored.
    - On move_done: direction updated next edge, turn_applied=1 for that cycle, pending cleared, go to RELEASE.
  - RELEASE: wait for one sample decoding to NONE -> LISTEN. This forces the player to withdraw the hand before the next turn.
- **Latency:** the confirming sample edge moves the FSM to PENDING. turn_pending rises on the next cycle. direction changes at the clock edge that samples move_done.
- **move_done outside PENDING:** no effect on direction.
- **Same-cycle confirm and move_done:** a move_done arriving in the same cycle as the confirming sample is not applied. The turn waits for the next move_done.
- **enable falling mid-operation:** next state IDLE, pending and counter cleared, direction held.
- **load_default:** has priority over all other inputs. direction=DIR_INIT, pending cleared, counter=0. Next state is LISTEN if enable=1, else IDLE. Any move_done in that cycle is ignored.
- **Registers:** all registers are updated on the rising clock edge only. There are no combinational paths from inputs to `direction`.

Decomposition:
- Shared package/header:
  - direction codes DIR_XP=2'b00, DIR_YP=2'b01, DIR_XN=2'b10, DIR_YN=2'b11. These are shared with the head-update mux and the wall-collision detector.
  - FSM state encodings.
  - command codes CMD_NONE/CMD_LEFT/CMD_RIGHT.
- One natural sub-module: sample_confirm_counter. It holds the candidate command, the saturating match counter and the `confirmed` pulse. The direction register and FSM stay in the top module.

Test Plan:
- **Reset:** reset pulse mid-PENDING -> direction=00, turn_pending=0, db_state=000 immediately (asynchronous).
- **Confirmed right turn:** enable=1, three samples dir=1 -> turn_pending=1. Then a move_done pulse -> direction 00->01, turn_applied high for exactly one cycle, db_state=100.
- **Left wrap and release rule:**
  - Start at 00, three LEFT samples, then move_done -> direction=11.
  - Further LEFT samples without an intermediate NONE -> no new pending.
  - One NONE sample, then three LEFT samples, then move_done -> direction=10.
- **Rejection cases:**
  - Samples RIGHT, RIGHT, NONE, RIGHT, RIGHT -> no turn_pending.
  - Samples with esq=dir=1 -> treated as NONE.
  - move_done pulses while in LISTEN -> direction unchanged.
- **Simultaneous events:** the third confirming sample and move_done in the same cycle -> direction unchanged. The next move_done applies the turn.
- **Priority:**
  - load_default together with move_done while PENDING (direction=10) -> direction=00, turn_pending=0, state LISTEN.
  - enable=0 -> db_state=000, and further samples are ignored.

Source files
------------

// File: rtl/snake_direction_ctrl_pkg.sv
// Shared codes for the snake direction path: heading, relative command and FSM state.
// The head-update mux and the wall-collision detector use the heading codes as well.
package snake_direction_ctrl_pkg;

    localparam logic [1:0] DIR_XP = 2'b00;
    localparam logic [1:0] DIR_YP = 2'b01;
    localparam logic [1:0] DIR_XN = 2'b10;
    localparam logic [1:0] DIR_YN = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LISTEN  = 3'b001,
        ST_CONFIRM = 3'b010,
        ST_PENDING = 3'b011,
        ST_RELEASE = 3'b100
    } state_t;

    // Both flags high is ambiguous and is treated as no command.
    function automatic cmd_t decode_cmd(input logic esq, input logic dir);
        case ({esq, dir})
            2'b10:   return CMD_LEFT;
            2'b01:   return CMD_RIGHT;
            default: return CMD_NONE;
        endcase
    endfunction

    // Relative turns wrap modulo 4, so a 180-degree reversal cannot be produced.
    function automatic logic [1:0] apply_turn(input logic [1:0] cur, input cmd_t cmd);
        case (cmd)
            CMD_RIGHT: return cur + 2'd1;
            CMD_LEFT:  return cur - 2'd1;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/snake_direction_ctrl_sample_confirm_counter.sv
// Candidate command plus saturating match counter; flags the sample that completes
// CONFIRM_SAMPLES identical commands in a row.
module sample_confirm_counter
    import snake_direction_ctrl_pkg::*;
#(
    parameter int CONFIRM_SAMPLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic sample,
    input  cmd_t cmd,
    output logic confirmed
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] match_count;
    cmd_t             candidate;
    logic             take;

    assign take = active && sample;

    always_comb begin
        match_count = CNT_W'(1);
        if (cmd == candidate && cmd != CMD_NONE)
            match_count = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    end

    assign confirmed = take && (cmd != CMD_NONE) && (match_count == CNT_W'(CONFIRM_SAMPLES));

    // Counter restarts after a confirmation so the next turn starts from scratch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            candidate <= CMD_NONE;
        end else if (clear || (take && (cmd == CMD_NONE || confirmed))) begin
            count     <= '0;
            candidate <= CMD_NONE;
        end else if (take) begin
            count     <= match_count;
            candidate <= cmd;
        end
    end

endmodule

// File: rtl/snake_direction_ctrl.sv
// Direction FSM for the snake: confirms a relative turn from the proximity flags,
// holds it pending and commits it to `direction` only on move_done.
module snake_direction_ctrl
    import snake_direction_ctrl_pkg::*;
#(
    parameter int         CONFIRM_SAMPLES = 3,
    parameter logic [1:0] DIR_INIT        = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_default,
    input  logic       sample,
    input  logic       esq,
    input  logic       dir,
    input  logic       move_done,
    output logic [1:0] direction,
    output logic       turn_pending,
    output logic       turn_applied,
    output logic [2:0] db_state
);

    state_t state;
    cmd_t   cmd;
    cmd_t   pend_cmd;
    logic   confirmed;
    logic   counting;

    assign cmd      = decode_cmd(esq, dir);
    assign db_state = state;
    assign counting = enable && !load_default &&
                      (state == ST_LISTEN || state == ST_CONFIRM);

    sample_confirm_counter #(
        .CONFIRM_SAMPLES(CONFIRM_SAMPLES)
    ) u_confirm (
        .clock    (clock),
        .reset    (reset),
        .clear    (!counting),
        .active   (counting),
        .sample   (sample),
        .cmd      (cmd),
        .confirmed(confirmed)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            direction    <= DIR_INIT;
            pend_cmd     <= CMD_NONE;
            turn_pending <= 1'b0;
            turn_applied <= 1'b0;
        end else begin
            turn_applied <= 1'b0;
            if (load_default) begin
                direction    <= DIR_INIT;
                pend_cmd     <= CMD_NONE;
                turn_pending <= 1'b0;
                state        <= enable ? ST_LISTEN : ST_IDLE;
            end else if (!enable) begin
                pend_cmd     <= CMD_NONE;
                turn_pending <= 1'b0;
                state        <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_LISTEN;
                    ST_LISTEN, ST_CONFIRM: begin
                        if (confirmed) begin
                            pend_cmd     <= cmd;
                            turn_pending <= 1'b1;
                            state        <= ST_PENDING;
                        end else if (sample) begin
                            state <= (cmd == CMD_NONE) ? ST_LISTEN : ST_CONFIRM;
                        end
                    end
                    // move_done is the only way out; samples are ignored here.
                    ST_PENDING: begin
                        if (move_done) begin
                            direction    <= apply_turn(direction, pend_cmd);
                            turn_applied <= 1'b1;
                            pend_cmd     <= CMD_NONE;
                            turn_pending <= 1'b0;
                            state        <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (sample && cmd == CMD_NONE)
                            state <= ST_LISTEN;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
